// File: rtl/spi_pingpong_rx.sv
// SPI-slave receiver feeding a two-bank ping-pong buffer.
// One bank fills from the serial side while the host drains the other.
module spi_pingpong_rx #(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned DEPTH       = 128,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              ssel,
    input  logic              mosi,
    output logic              miso,
    output logic              frame_ready,
    output logic [ADDR_W:0]   frame_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              frame_ack,
    output logic              overflow
);

    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W:0]   FULL     = (ADDR_W + 1)'(DEPTH);

    typedef enum logic { W_FILL, W_HOLD } wstate_t;
    typedef enum logic { R_IDLE, R_READY } rstate_t;

    logic [SYNC_STAGES-1:0] sck_sync, ssel_sync, mosi_sync;
    logic                   sck_d, ssel_d;
    logic                   sck_s, ssel_s, mosi_s;
    logic                   sck_rise, sck_fall, lead, trail;
    logic                   sample_edge, shift_edge, ssel_rise, ssel_fall;

    logic [BIT_W-1:0]       bitcnt;
    logic [WORD_W-2:0]      shreg;
    logic [WORD_W-1:0]      new_word;
    logic [WORD_W-1:0]      word_data;
    logic                   word_valid;
    logic                   word_last;
    logic [WORD_W-1:0]      tx;
    logic                   miso_r;

    wstate_t                wstate, wstate_nx;
    rstate_t                rstate, rstate_nx;
    logic                   wbank, wbank_nx;
    logic [ADDR_W:0]        wr_ptr, wr_ptr_nx;
    logic [ADDR_W:0]        frame_len_nx;
    logic                   overflow_nx;
    logic                   swap_req, ack_ok, do_swap;
    logic                   mem_we, mem_bank;
    logic [ADDR_W-1:0]      mem_addr;

    logic [WORD_W-1:0]      mem [2*DEPTH];

    // ---------------- input synchronisers and edge detection ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            ssel_sync <= '1;
            mosi_sync <= '0;
            sck_d     <= CPOL;
            ssel_d    <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], ssel};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            ssel_d    <= ssel_s;
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign ssel_s      = ssel_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign lead        = CPOL ? sck_fall : sck_rise;
    assign trail       = CPOL ? sck_rise : sck_fall;
    assign sample_edge = ~ssel_s & (CPHA ? trail : lead);
    assign shift_edge  = ~ssel_s & (CPHA ? lead : trail);
    assign ssel_rise   = ssel_s & ~ssel_d;
    assign ssel_fall   = ~ssel_s & ssel_d;
    assign new_word    = {shreg, mosi_s};
    assign word_last   = (bitcnt == LAST_BIT);

    // ---------------- receive shifter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt     <= '0;
            shreg      <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (ssel_rise) begin
                bitcnt <= '0;
            end else if (sample_edge) begin
                shreg <= new_word[WORD_W-2:0];
                if (word_last) begin
                    bitcnt     <= '0;
                    word_valid <= 1'b1;
                    word_data  <= new_word;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end
        end
    end

    // ---------------- loopback transmitter ----------------
    // In CPHA=0 the MSB is already on the line when the word loads, so the
    // trailing edge at a word boundary must not shift it away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx     <= '0;
            miso_r <= 1'b0;
        end else if (ssel_fall) begin
            tx     <= word_data;
            miso_r <= 1'b0;
        end else if (sample_edge && word_last) begin
            tx <= new_word;
        end else if (shift_edge && (CPHA || bitcnt != '0)) begin
            miso_r <= tx[WORD_W-1];
            tx     <= {tx[WORD_W-2:0], 1'b0};
        end
    end

    assign miso = ~ssel_s & (CPHA ? miso_r : tx[WORD_W-1]);

    // ---------------- bank control FSMs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate    <= W_FILL;
            rstate    <= R_IDLE;
            wbank     <= 1'b0;
            wr_ptr    <= '0;
            frame_len <= '0;
            overflow  <= 1'b0;
        end else begin
            wstate    <= wstate_nx;
            rstate    <= rstate_nx;
            wbank     <= wbank_nx;
            wr_ptr    <= wr_ptr_nx;
            frame_len <= frame_len_nx;
            overflow  <= overflow_nx;
        end
    end

    // The ack is applied before any swap decision in the same cycle.
    always_comb begin
        wstate_nx    = wstate;
        rstate_nx    = rstate;
        wbank_nx     = wbank;
        wr_ptr_nx    = wr_ptr;
        frame_len_nx = frame_len;
        overflow_nx  = overflow;
        do_swap      = 1'b0;
        mem_we       = 1'b0;
        mem_bank     = wbank;
        mem_addr     = wr_ptr[ADDR_W-1:0];
        swap_req     = (wr_ptr == FULL) || (ssel_rise && wr_ptr != '0);
        ack_ok       = frame_ack && (rstate == R_READY);

        if (ack_ok) begin
            rstate_nx = R_IDLE;
            if (overflow) overflow_nx = 1'b0;
        end

        case (wstate)
            W_FILL: begin
                if (swap_req) begin
                    if (rstate == R_IDLE || ack_ok) do_swap = 1'b1;
                    else                            wstate_nx = W_HOLD;
                end else if (word_valid) begin
                    mem_we    = 1'b1;
                    wr_ptr_nx = wr_ptr + 1'b1;
                end
            end
            W_HOLD: begin
                if (ack_ok) begin
                    do_swap   = 1'b1;
                    wstate_nx = W_FILL;
                end else if (word_valid) begin
                    overflow_nx = 1'b1;
                end
            end
            default: wstate_nx = W_FILL;
        endcase

        if (do_swap) begin
            wbank_nx     = ~wbank;
            frame_len_nx = wr_ptr;
            wr_ptr_nx    = '0;
            rstate_nx    = R_READY;
            if (wstate == W_HOLD && word_valid) begin
                mem_we    = 1'b1;
                mem_bank  = ~wbank;
                mem_addr  = '0;
                wr_ptr_nx = (ADDR_W + 1)'(1);
            end
        end
    end

    assign frame_ready = (rstate == R_READY);

    // ---------------- bank storage ----------------
    always_ff @(posedge clk) begin
        if (mem_we) mem[{mem_bank, mem_addr}] <= word_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[{~wbank, rd_addr}];
    end

endmodule
